// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the IF stage: reset/base addresses, the
// next-PC select encoding, and the branch offset helper.
package fetch_stage_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   // Sign-extended word offset of a conditional branch, in bytes.
   function automatic logic [31:0] br_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// Redirect decoder for the IF stage. Reports which next-PC source wins and
// the redirect target. The sequential address is formed beside the PC
// register, so the target is meaningful only when sel is not NPC_SEQ.
module fetch_stage_npc_sel
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc_id,
   input  logic        br_en,
   input  logic        cmp_zero,
   input  logic [15:0] br_imm16,
   input  logic        j_en,
   input  logic [25:0] j_idx26,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output npc_sel_e    sel,
   output logic [31:0] target
);

   // Priority jr > j > taken branch > sequential; a not-taken branch falls through.
   always_comb begin
      sel    = NPC_SEQ;
      target = pc_id + 32'd4 + br_offset(br_imm16);
      if (jr_en) begin
         sel    = NPC_JR;
         target = jr_target;
      end else if (j_en) begin
         sel    = NPC_J;
         target = {pc_id[31:28], j_idx26, 2'b00};
      end else if (br_en && cmp_zero) begin
         sel    = NPC_BR;
         target = pc_id + 32'd4 + br_offset(br_imm16);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register. Holds the fetch PC, forms the
// instruction-memory word index and latches the fetched instruction with
// its PC. Redirects decided in ID land one cycle later; the instruction
// already in IF is the delay slot and is never squashed.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter int          IM_AW    = 12
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [31:0]      im_instr,
   input  logic             br_en,
   input  logic             cmp_zero,
   input  logic [15:0]      br_imm16,
   input  logic             j_en,
   input  logic [25:0]      j_idx26,
   input  logic             jr_en,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc_if,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      instr_id,
   output logic [31:0]      pc_id,
   output logic [31:0]      pc8_id
);

   logic [31:0] pc_if_q, pc_if_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic [31:0] pc_id_q, pc_id_d;
   npc_sel_e    npc_sel;
   logic [31:0] redirect_target;
   logic [31:0] npc;

   fetch_stage_npc_sel u_npc_sel (
      .pc_id     (pc_id_q),
      .br_en     (br_en),
      .cmp_zero  (cmp_zero),
      .br_imm16  (br_imm16),
      .j_en      (j_en),
      .j_idx26   (j_idx26),
      .jr_en     (jr_en),
      .jr_target (jr_target),
      .sel       (npc_sel),
      .target    (redirect_target)
   );

   // Next fetch address: sequential unless the ID instruction redirects.
   always_comb begin
      npc = pc_if_q + 32'd4;
      if (npc_sel != NPC_SEQ) begin
         npc = redirect_target;
      end
   end

   // Advance PC and IF/ID together; a stall freezes both and drops any redirect.
   always_comb begin
      pc_if_d    = pc_if_q;
      instr_id_d = instr_id_q;
      pc_id_d    = pc_id_q;
      if (!stall) begin
         pc_if_d    = npc;
         instr_id_d = im_instr;
         pc_id_d    = pc_if_q;
      end
   end

   // PC and IF/ID registers; reset loads the boot PC and a nop into ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_if_q    <= RESET_PC;
         instr_id_q <= 32'h0;
         pc_id_q    <= RESET_PC;
      end else begin
         pc_if_q    <= pc_if_d;
         instr_id_q <= instr_id_d;
         pc_id_q    <= pc_id_d;
      end
   end

   assign pc_if    = pc_if_q;
   assign instr_id = instr_id_q;
   assign pc_id    = pc_id_q;
   assign pc8_id   = pc_id_q + 32'd8;
   assign im_addr  = IM_AW'((pc_if_q - IM_BASE) >> 2);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected post-edge state is pushed to a
// scoreboard when stimulus is driven and popped after the clock edge.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [31:0] im_instr;
   logic        br_en;
   logic        cmp_zero;
   logic [15:0] br_imm16;
   logic        j_en;
   logic [25:0] j_idx26;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc_if;
   logic [11:0] im_addr;
   logic [31:0] instr_id;
   logic [31:0] pc_id;
   logic [31:0] pc8_id;

   typedef struct packed {
      logic [31:0] pc_if;
      logic [31:0] pc_id;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic [11:0] im_addr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   fetch_stage dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .im_instr  (im_instr),
      .br_en     (br_en),
      .cmp_zero  (cmp_zero),
      .br_imm16  (br_imm16),
      .j_en      (j_en),
      .j_idx26   (j_idx26),
      .jr_en     (jr_en),
      .jr_target (jr_target),
      .pc_if     (pc_if),
      .im_addr   (im_addr),
      .instr_id  (instr_id),
      .pc_id     (pc_id),
      .pc8_id    (pc8_id)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory model: each word encodes its own index.
   always_comb begin
      im_instr = 32'hC0DE_0000 | {20'h0, im_addr};
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [11:0] idx_of(input logic [31:0] pc);
      return 12'((pc - 32'h0000_3000) >> 2);
   endfunction

   function automatic logic [31:0] instr_at(input logic [31:0] pc);
      return 32'hC0DE_0000 | {20'h0, idx_of(pc)};
   endfunction

   task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      assert (got === exp) passes = passes + 1;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic expectState(input logic [31:0] pc_if_e, input logic [31:0] pc_id_e,
                              input logic [31:0] instr_e);
      exp_t e;
      e.pc_if   = pc_if_e;
      e.pc_id   = pc_id_e;
      e.instr   = instr_e;
      e.pc8     = pc_id_e + 32'd8;
      e.im_addr = idx_of(pc_if_e);
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks = checks + 1;
         $error("[TB] FAIL %s: observed empty scoreboard expected one entry", tag);
         return;
      end
      e = sb.pop_front();
      checkField({tag, ".pc_if"}, pc_if, e.pc_if);
      checkField({tag, ".pc_id"}, pc_id, e.pc_id);
      checkField({tag, ".instr_id"}, instr_id, e.instr);
      checkField({tag, ".pc8_id"}, pc8_id, e.pc8);
      checkField({tag, ".im_addr"}, {20'h0, im_addr}, {20'h0, e.im_addr});
   endtask

   task automatic applyStimulus(input logic st, input logic br, input logic cz,
                                input logic [15:0] imm, input logic je,
                                input logic [25:0] idx, input logic jre,
                                input logic [31:0] jrt);
      stall     = st;
      br_en     = br;
      cmp_zero  = cz;
      br_imm16  = imm;
      j_en      = je;
      j_idx26   = idx;
      jr_en     = jre;
      jr_target = jrt;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
   endtask

   task automatic step(input string tag, input logic [31:0] pc_if_e,
                       input logic [31:0] pc_id_e, input logic [31:0] instr_e);
      expectState(pc_if_e, pc_id_e, instr_e);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Assert reset between edges, check it took effect at once, hold it
   // across an edge, then release between edges.
   task automatic pulseReset(input string tag);
      #3 reset = 1'b1;
      #1;
      expectState(32'h3000, 32'h3000, 32'h0);
      checkOutput(tag);
      @(posedge clk);
      #1;
      expectState(32'h3000, 32'h3000, 32'h0);
      checkOutput({tag, "_held"});
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #1;
      expectState(32'h3000, 32'h3000, 32'h0);
      checkOutput("reset_init");
      @(posedge clk);
      #1;
      reset = 1'b0;

      step("seq0", 32'h3004, 32'h3000, instr_at(32'h3000));
      step("seq1", 32'h3008, 32'h3004, instr_at(32'h3004));
      step("seq2", 32'h300C, 32'h3008, instr_at(32'h3008));

      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
      step("br_taken_slot", 32'h3018, 32'h300C, instr_at(32'h300C));
      idle();
      step("br_taken_target", 32'h301C, 32'h3018, instr_at(32'h3018));

      pulseReset("reset_async");
      step("resume0", 32'h3004, 32'h3000, instr_at(32'h3000));
      step("resume1", 32'h3008, 32'h3004, instr_at(32'h3004));
      step("resume2", 32'h300C, 32'h3008, instr_at(32'h3008));
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
      step("br_not_taken", 32'h3010, 32'h300C, instr_at(32'h300C));
      idle();

      pulseReset("reset_b");
      step("rb0", 32'h3004, 32'h3000, instr_at(32'h3000));
      step("rb1", 32'h3008, 32'h3004, instr_at(32'h3004));
      step("rb2", 32'h300C, 32'h3008, instr_at(32'h3008));
      applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
      step("br_backward", 32'h3008, 32'h300C, instr_at(32'h300C));
      idle();

      pulseReset("reset_j");
      step("rj0", 32'h3004, 32'h3000, instr_at(32'h3000));
      step("rj1_pc8", 32'h3008, 32'h3004, instr_at(32'h3004));
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C10, 1'b0, 32'h0);
      step("jal", 32'h3040, 32'h3008, instr_at(32'h3008));
      idle();
      step("jal_next", 32'h3044, 32'h3040, instr_at(32'h3040));

      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0);
      step("stall0", 32'h3044, 32'h3040, instr_at(32'h3040));
      step("stall1", 32'h3044, 32'h3040, instr_at(32'h3040));
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0);
      step("stall_release_br", 32'h3084, 32'h3044, instr_at(32'h3044));
      idle();
      step("br_once", 32'h3088, 32'h3084, instr_at(32'h3084));

      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h3FFFFFF, 1'b1, 32'h0000_3100);
      step("jr_wins", 32'h3100, 32'h3088, instr_at(32'h3088));
      idle();
      step("jr_next", 32'h3104, 32'h3100, instr_at(32'h3100));

      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
      step("jr_top", 32'hFFFF_FFFC, 32'h3104, instr_at(32'h3104));
      idle();
      step("wrap", 32'h0000_0000, 32'hFFFF_FFFC, instr_at(32'hFFFF_FFFC));
      step("wrap_next", 32'h0000_0004, 32'h0000_0000, instr_at(32'h0000_0000));

      if (sb.size() != 0) begin
         checks = checks + 1;
         $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
